// File: rtl/vga_vram_arbiter.sv
// Purpose : shares one single-port video RAM between the VGA cell fetch path and a req/ack writer.
// Latency : fetch D -> cell_data valid 3 clk later (start of next cell); write grant t -> ram_we/wr_ack in t+1.
// Backpr. : display fetch always wins; writer waits in IDLE (no ack) until a free, allowed cycle.
//
// Ports:
//   clk, reset            system clock (2x pixel rate), asynchronous active-low reset
//   p_tick, pixel_x/y     sync generator timing; fetch schedule is derived from these
//   wr_req/addr/data      writer request, held stable until wr_ack
//   wr_ack, wr_err        one-cycle completion pulse; wr_err flags an out-of-range address
//   ram_addr/we/wdata     registered RAM controls; ram_rdata returns one clk after address
//   cell_data             word of the cell currently under the beam
module vga_vram_arbiter #(
  parameter int DW       = 8,
  parameter bit BLANK_WR = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_tick,
  input  logic [9:0]    pixel_x,
  input  logic [9:0]    pixel_y,
  input  logic          wr_req,
  input  logic [12:0]   wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic          wr_err,
  output logic [12:0]   ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [DW-1:0] cell_data
);

  localparam logic [12:0] NCELLS = 13'd4800;

  typedef enum logic {S_IDLE, S_ACK} state_t;

  state_t        state_q, state_d;
  logic [12:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;

  // Fetch pipeline: fv1 = address on RAM, fv2 = read data on ram_rdata.
  logic          fv1_q, fv2_q;
  logic          slot_q;
  logic [DW-1:0] next_cell_q, cell_q;

  // Display decision: the mid-line slot fetches the next cell on this line,
  // the x=798 slot prefetches column 0 of the following line.
  logic [9:0]  line_nxt;
  logic        d_mid, d_wrap, d_cyc;
  logic [6:0]  row, col;
  logic [12:0] target;
  logic        grant, load;

  assign line_nxt = (pixel_y == 10'd524) ? 10'd0 : pixel_y + 10'd1;
  assign d_mid    = !p_tick && (pixel_x[2:0] == 3'd6) && (pixel_x < 10'd632) && (pixel_y < 10'd480);
  assign d_wrap   = !p_tick && (pixel_x == 10'd798) && (line_nxt < 10'd480);
  assign d_cyc    = d_mid || d_wrap;

  assign row    = d_wrap ? line_nxt[9:3] : pixel_y[9:3];
  assign col    = d_wrap ? 7'd0 : pixel_x[9:3] + 7'd1;
  // row*80 as (row<<6)+(row<<4)
  assign target = {row, 6'b0} + {2'b0, row, 4'b0} + {6'b0, col};

  // No grant from ACK: a still-high wr_req in the ack cycle is not served twice.
  assign grant = (state_q == S_IDLE) && wr_req && !d_cyc &&
                 (!BLANK_WR || (pixel_y >= 10'd480));

  // cell_data updates on the last tick of each cell so it is valid from the cell's first pixel.
  assign load = p_tick && (pixel_x[2:0] == 3'd7);

  always_comb begin
    state_d = S_IDLE;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    if (d_cyc) begin
      addr_d = target;
    end else if (grant) begin
      state_d = S_ACK;
      addr_d  = wr_addr;
      wdata_d = wr_data;
      we_d    = (wr_addr < NCELLS);
      ack_d   = 1'b1;
      err_d   = (wr_addr >= NCELLS);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fv1_q       <= 1'b0;
      fv2_q       <= 1'b0;
      slot_q      <= 1'b0;
      next_cell_q <= '0;
      cell_q      <= '0;
    end else begin
      fv1_q <= d_cyc;
      fv2_q <= fv1_q;
      if (fv2_q) begin
        next_cell_q <= ram_rdata;
        slot_q      <= 1'b1;
      end else if (load) begin
        slot_q <= 1'b0;
      end
      if (load && slot_q) begin
        cell_q <= next_cell_q;
      end
    end
  end

  assign ram_addr  = addr_q;
  assign ram_we    = we_q;
  assign ram_wdata = wdata_q;
  assign wr_ack    = ack_q;
  assign wr_err    = err_q;
  assign cell_data = cell_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Purpose : self-checking bench for vga_vram_arbiter (cell fetch, write arbitration, blanking-only writes).
// Latency : bench drives inputs 1 time unit after posedge, samples outputs on negedge.
// Backpr. : every wait is bounded; an expired bound counts as a failure.
module tb_vga_vram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        p_tick;
  logic [9:0]  pixel_x, pixel_y;
  logic        wr_req, wr_req2;
  logic [12:0] wr_addr, wr_addr2;
  logic [7:0]  wr_data, wr_data2;
  logic        wr_ack, wr_err, ram_we;
  logic        wr_ack2, wr_err2, ram_we2;
  logic [12:0] ram_addr, ram_addr2;
  logic [7:0]  ram_wdata, ram_rdata, cell_data;
  logic [7:0]  ram_wdata2, ram_rdata2, cell_data2;

  logic [7:0]  mem [0:8191];
  logic        load_mem;

  int checks;
  int failures;

  typedef struct {
    int         y;
    int         col;
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[9];

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
    logic        err;
  } wexp_t;
  wexp_t sb[$];

  vga_vram_arbiter #(.DW(8), .BLANK_WR(1'b0)) dut (
    .clk(clk), .reset(rst_n), .p_tick(p_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack), .wr_err(wr_err),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .cell_data(cell_data)
  );

  vga_vram_arbiter #(.DW(8), .BLANK_WR(1'b1)) dut2 (
    .clk(clk), .reset(rst_n), .p_tick(p_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .wr_req(wr_req2), .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_ack(wr_ack2), .wr_err(wr_err2),
    .ram_addr(ram_addr2), .ram_we(ram_we2), .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2),
    .cell_data(cell_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM; dut2 only reads the same contents.
  always @(posedge clk) begin
    if (load_mem) begin
      for (int k = 0; k < 8192; k++) mem[k] <= 8'(k);
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata  <= mem[ram_addr];
    ram_rdata2 <= mem[ram_addr2];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Pops the scoreboard on every ack; any write strobe without a pending request is flagged.
  task automatic monitor();
    wexp_t e;
    if (wr_ack) begin
      if (sb.size() == 0) begin
        chk("spurious_ack", 32'(wr_ack), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("ack_ram_addr", 32'(ram_addr), 32'(e.addr));
        chk("ack_wr_err", 32'(wr_err), 32'(e.err));
        chk("ack_ram_we", 32'(ram_we), 32'(!e.err));
        if (!e.err) chk("ack_ram_wdata", 32'(ram_wdata), 32'(e.data));
      end
    end else if (ram_we || wr_err) begin
      chk("we_or_err_without_ack", 32'({ram_we, wr_err}), 32'd0);
    end
  endtask

  // One clk: sync-generator advance after the edge, then sample at negedge.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (p_tick) begin
      if (pixel_x == 10'd799) begin
        pixel_x = 10'd0;
        pixel_y = (pixel_y == 10'd524) ? 10'd0 : pixel_y + 10'd1;
      end else begin
        pixel_x = pixel_x + 10'd1;
      end
    end
    p_tick = ~p_tick;
    @(negedge clk);
    monitor();
  endtask

  task automatic set_pos(input int x, input int y);
    pixel_x = x[9:0];
    pixel_y = y[9:0];
    p_tick  = 1'b0;
  endtask

  task automatic wr_and_wait(input logic [12:0] a, input logic [7:0] d, input string name);
    wexp_t e;
    bit    seen;
    int    lat;
    e.addr = a;
    e.data = d;
    e.err  = (a >= 13'd4800);
    sb.push_back(e);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    seen    = 1'b0;
    lat     = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      cyc();
      lat++;
      if (wr_ack) seen = 1'b1;
    end
    chk({name, "_acked"}, 32'(seen), 32'd1);
    chk({name, "_latency"}, 32'(lat), 32'd1);
    cyc();  // wr_req still high across the ack cycle
    chk({name, "_no_regrant"}, 32'({wr_ack, ram_we, wr_err}), 32'd0);
    wr_req = 1'b0;
  endtask

  initial begin
    bit seen2;
    checks   = 0;
    failures = 0;
    vecs[0] = '{16, 3, 8'd163};
    vecs[1] = '{479, 0, 8'd112};
    vecs[2] = '{0, 0, 8'd0};
    vecs[3] = '{100, 79, 8'd15};
    vecs[4] = '{255, 40, 8'd216};
    vecs[5] = '{7, 1, 8'd1};
    vecs[6] = '{200, 0, 8'd208};
    vecs[7] = '{23, 79, 8'd239};
    vecs[8] = '{8, 20, 8'hA5};

    rst_n    = 1'b0;
    load_mem = 1'b1;
    wr_req   = 1'b0; wr_addr  = '0; wr_data  = '0;
    wr_req2  = 1'b0; wr_addr2 = '0; wr_data2 = '0;
    set_pos(0, 0);
    repeat (3) cyc();
    load_mem = 1'b0;
    chk("reset_outputs", 32'({ram_addr, ram_we, ram_wdata, wr_ack, wr_err, cell_data}), 32'd0);
    rst_n = 1'b1;

    // Write collides with a display decision cycle: deferred by one clk.
    set_pos(6, 16);
    wr_req = 1'b1; wr_addr = 13'd100; wr_data = 8'hA5;
    sb.push_back('{13'd100, 8'hA5, 1'b0});
    cyc();
    chk("coll_we_deferred", 32'(ram_we), 32'd0);
    chk("coll_fetch_addr", 32'(ram_addr), 32'd161);
    chk("coll_no_ack_yet", 32'(wr_ack), 32'd0);
    cyc();
    chk("coll_ack", 32'(wr_ack), 32'd1);
    cyc();
    chk("coll_ack_one_cycle", 32'(wr_ack), 32'd0);
    wr_req = 1'b0;
    chk("ram100_written", 32'(mem[100]), 32'hA5);

    // Writes in vertical blank, including an out-of-range address.
    set_pos(100, 600);
    wr_and_wait(13'd200, 8'h3C, "wr200");
    wr_and_wait(13'd201, 8'h5A, "wr201");
    wr_and_wait(13'd4800, 8'hEE, "wr4800");
    chk("ram200", 32'(mem[200]), 32'h3C);
    chk("ram201", 32'(mem[201]), 32'h5A);
    chk("ram4800_untouched", 32'(mem[4800]), 32'd192);

    // Cell fetch table: start one cell early so the fetch for the target cell is issued.
    for (int i = 0; i < 9; i++) begin
      int sx, sy;
      sy = (vecs[i].col == 0) ? ((vecs[i].y == 0) ? 524 : vecs[i].y - 1) : vecs[i].y;
      sx = (vecs[i].col == 0) ? 792 : vecs[i].col * 8 - 8;
      set_pos(sx, sy);
      repeat (16) cyc();
      for (int k = 0; k < 16; k++) begin
        chk($sformatf("cell_v%0d_s%0d", i, k), 32'(cell_data), 32'(vecs[i].exp));
        cyc();
      end
    end

    // Asynchronous reset in the middle of a line.
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_addr", 32'(ram_addr), 32'd0);
    chk("async_rst_misc", 32'({ram_we, ram_wdata, wr_ack, wr_err}), 32'd0);
    chk("async_rst_cell", 32'(cell_data), 32'd0);
    cyc();
    set_pos(8, 16);
    rst_n = 1'b1;
    for (int n = 0; n < 12; n++) begin
      cyc();
      chk($sformatf("post_rst_addr_%0d", n), 32'(ram_addr), 32'd0);
    end
    cyc();
    chk("first_d_addr", 32'(ram_addr), 32'd162);
    chk("first_d_we", 32'(ram_we), 32'd0);
    cyc();
    cyc();
    chk("cell_before_load", 32'(cell_data), 32'd0);
    cyc();
    chk("cell_first_fetch", 32'(cell_data), 32'd162);

    // Frame wrap: x=798 on the last line fetches row 0 column 0.
    set_pos(798, 524);
    cyc();
    chk("wrap_addr", 32'(ram_addr), 32'd0);
    chk("wrap_we", 32'(ram_we), 32'd0);

    // Blank-only writer: request in active video waits for pixel_y=480.
    set_pos(100, 100);
    wr_req2 = 1'b1; wr_addr2 = 13'd300; wr_data2 = 8'h77;
    for (int n = 0; n < 40; n++) begin
      cyc();
      chk($sformatf("blank_wait_%0d", n), 32'({wr_ack2, ram_we2}), 32'd0);
    end
    set_pos(780, 479);
    seen2 = 1'b0;
    for (int n = 0; n < 200 && !seen2; n++) begin
      cyc();
      if (wr_ack2) seen2 = 1'b1;
    end
    chk("blank_acked", 32'(seen2), 32'd1);
    chk("blank_ack_pos", 32'({pixel_y, pixel_x, p_tick}), 32'({10'd480, 10'd0, 1'b1}));
    chk("blank_ram", 32'({ram_we2, wr_err2, ram_addr2, ram_wdata2}), 32'({1'b1, 1'b0, 13'd300, 8'h77}));
    cyc();
    chk("blank_ack_one_cycle", 32'(wr_ack2), 32'd0);
    wr_req2 = 1'b0;
    cyc();

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
